// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, request record and the address-check helper.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_STRB_W = 4;
    localparam int unsigned DMEM_CNT_W  = 4;

    localparam logic DMEM_ERR_NONE = 1'b0;
    localparam logic DMEM_ERR_ADDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_STRB_W-1:0] wstrb;
    } dmem_req_t;

    // Underflow of addr-base wraps to a huge word offset, so it also trips the range test.
    function automatic logic dmem_addr_err(
        input logic [DMEM_ADDR_W-1:0] addr,
        input logic [DMEM_ADDR_W-1:0] base,
        input logic [31:0]            depth_words
    );
        logic [29:0] word_off;
        word_off = 30'((addr - base) >> 2);
        return (addr[1:0] != 2'b00) || (addr < base) || ({2'b00, word_off} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only updates on enabled loads, so it holds its value otherwise.
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [DMEM_STRB_W-1:0] be_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DMEM_DATA_W-1:0] wdata_i,
    output logic [DMEM_DATA_W-1:0] rdata_o
);

    logic [DMEM_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DMEM_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DMEM_STRB_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core load/store port: one request at a time,
// response after a fixed LATENCY, byte-strobed stores and address error flagging.
//
//   state | meaning
//   IDLE  | ready for a request; accept captures it
//   WAIT  | latency counter running, counts up from 1 to LATENCY-1
//   RESP  | response presented; held until rsp_ready_i
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned      DEPTH_WORDS = 1024,
    parameter int unsigned      LATENCY     = 2,
    parameter logic [31:0]      BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [DMEM_ADDR_W-1:0] req_addr_i,
    input  logic [DMEM_DATA_W-1:0] req_wdata_i,
    input  logic [DMEM_STRB_W-1:0] req_wstrb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DMEM_DATA_W-1:0] rsp_rdata_o,
    output logic                   rsp_err_o
);

    localparam int unsigned          AW       = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] LAT_LAST = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
    dmem_req_t               req_q, req_d;
    dmem_req_t               req_in;
    dmem_req_t               cur_req;
    logic                    cur_err;
    logic                    enter_resp;
    logic [AW-1:0]           word_idx;
    logic                    ram_en;
    logic                    ram_we;
    logic [DMEM_DATA_W-1:0]  ram_rdata;

    assign req_in = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, wstrb: req_wstrb_i};

    // With LATENCY=1 the array is accessed on the accept edge itself, before req_q is loaded.
    assign cur_req    = (state_q == IDLE) ? req_in : req_q;
    assign cur_err    = dmem_addr_err(cur_req.addr, BASE_ADDR, DEPTH_WORDS) ? DMEM_ERR_ADDR
                                                                           : DMEM_ERR_NONE;
    assign word_idx   = AW'((cur_req.addr - BASE_ADDR) >> 2);
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // Gating on reset_i keeps a reset coincident with the RESP-entry edge from committing a store.
    assign ram_en = enter_resp && !reset_i;
    assign ram_we = cur_req.we && (cur_err == DMEM_ERR_NONE);

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (cur_req.wstrb),
        .addr_i  (word_idx),
        .wdata_i (cur_req.wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_d = req_in;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = DMEM_CNT_W'(1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DMEM_CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = DMEM_ERR_NONE;
        unique case (state_q)
            IDLE: req_ready_o = 1'b1;
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = cur_err;
                if (!req_q.we && (cur_err == DMEM_ERR_NONE)) begin
                    rsp_rdata_o = ram_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for most steps
// and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) dut_l1 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_wstrb_i(b_req_wstrb),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the LATENCY=2 instance with rsp_ready held high.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        n = 0;
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        do begin
            step();
            n++;
            req_valid = 1'b0;
        end while (!rsp_valid && n < 20);
        chk({tag, "_lat"},   32'(n), 32'd2);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"},   32'(rsp_err), 32'(exp_err));
        step();
        chk({tag, "_vld_off"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0; b_rsp_ready = 1;
        step();
        step();
        chk("rst_vld",   32'(rsp_valid), 32'd0);
        chk("rst_rdy",   32'(req_ready), 32'd1);
        chk("rst_rdata", rsp_rdata,      32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        reset = 1'b0;
        step();

        // Basic store/load
        xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xact("ld10", 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);

        // Byte strobes and empty strobe
        xact("st20",  1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xact("st20b", 1'b1, 32'h20, 32'h000000AA, 4'h1, 32'h0, 1'b0);
        xact("ld20",  1'b0, 32'h20, 32'h0,        4'h0, 32'h112233AA, 1'b0);
        xact("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        xact("ld20z", 1'b0, 32'h20, 32'h0,        4'h0, 32'h112233AA, 1'b0);

        // Address errors and top-of-array boundary
        xact("ld22",  1'b0, 32'h22,       32'h0, 4'h0, 32'h0, 1'b1);
        xact("ldoob", 1'b0, 32'h1000,     32'h0, 4'h0, 32'h0, 1'b1);
        xact("ldneg", 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("stffc", 1'b1, 32'hFFC, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xact("ldffc", 1'b0, 32'hFFC, 32'h0,        4'h0, 32'h12345678, 1'b0);
        xact("st22",  1'b1, 32'h22,  32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        xact("ld20e", 1'b0, 32'h20,  32'h0,        4'h0, 32'h112233AA, 1'b0);

        // Back-pressure with a second request waiting
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        step();
        chk("bp_wait_vld", 32'(rsp_valid), 32'd0);
        req_addr = 32'h20;
        step();
        chk("bp_vld",   32'(rsp_valid), 32'd1);
        chk("bp_rdata", rsp_rdata,      32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_vld",   32'(rsp_valid), 32'd1);
            chk("bp_hold_rdata", rsp_rdata,      32'hDEADBEEF);
            chk("bp_hold_rdy",   32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_vld", 32'(rsp_valid), 32'd0);
        chk("bp_idle_rdy", 32'(req_ready), 32'd1);
        step();
        chk("bp_2nd_acc_rdy", 32'(req_ready), 32'd0);
        chk("bp_2nd_acc_vld", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        step();
        chk("bp_2nd_vld",   32'(rsp_valid), 32'd1);
        chk("bp_2nd_rdata", rsp_rdata,      32'h112233AA);
        step();
        chk("bp_2nd_done", 32'(rsp_valid), 32'd0);

        // Reset while presenting a response drops it without a clock edge
        xact("st30", 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
        step();
        req_valid = 1'b0;
        step();
        chk("rr_vld",   32'(rsp_valid), 32'd1);
        chk("rr_rdata", rsp_rdata,      32'h0BADF00D);
        #2;
        reset = 1'b1;
        #1;
        chk("rr_drop_vld",   32'(rsp_valid), 32'd0);
        chk("rr_drop_rdata", rsp_rdata,      32'd0);
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        step();

        // Reset one cycle after accepting a store: no commit
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55AA55AA; req_wstrb = 4'hF;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rw_vld", 32'(rsp_valid), 32'd0);
        step();
        reset = 1'b0;
        step();
        xact("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);

        // LATENCY=1 instance: store then back-to-back loads
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h40; b_req_wdata = 32'hCAFEF00D; b_req_wstrb = 4'hF;
        step();
        chk("l1_st_vld", 32'(b_rsp_valid), 32'd1);
        chk("l1_st_err", 32'(b_rsp_err),   32'd0);
        chk("l1_st_rdy", 32'(b_req_ready), 32'd0);
        b_req_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("l1_idle_vld", 32'(b_rsp_valid), 32'd0);
            chk("l1_idle_rdy", 32'(b_req_ready), 32'd1);
            step();
            chk("l1_ld_vld",   32'(b_rsp_valid), 32'd1);
            chk("l1_ld_rdata", b_rsp_rdata,      32'hCAFEF00D);
        end
        b_req_valid = 1'b0;
        step();
        chk("l1_done", 32'(b_rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
